// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the memory-mapped timer: bus command
//               codes, register offsets inside the 4-word window, CTRL bit
//               positions and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    // CPU memory bus command codes
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // Word offsets inside the register window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // CTRL register bit positions
    localparam int EN   = 0;
    localparam int AUTO = 1;
    localparam int IE   = 2;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Prescaler for the timer. Counts clock cycles while 'run' is
//               high and pulses 'tick' on the cycle the prescaler reaches
//               PRESCALE-1, wrapping back to 0 on that edge.
// Ports       : clk   - system clock
//               reset - asynchronous active-low reset
//               run   - count enable (controller is running and not stopping)
//               clr   - synchronous clear (timer start); overrides run
//               tick  - one-cycle tick, combinational from prescaler state
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int PRESCALE = 50000      // must be >= 1; 1 ticks every cycle
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    // A PRESCALE of 1 still needs a 1-bit counter that simply stays at 0.
    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_q;
    logic [CW-1:0] presc_d;

    assign tick = run && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// Module      : mmio_timer
// Description : 16-bit memory-mapped down-counter timer. Decodes a 4-word
//               window at BASE (CTRL, LOAD, COUNT, STATUS), supports one-shot
//               and auto-reload operation and raises a level interrupt while
//               the sticky expired flag and CTRL.IE are both set.
// Ports       : clk        - system clock
//               reset      - asynchronous active-low reset
//               mem_cmd    - bus command (MNONE/MREAD/MWRITE)
//               mem_addr   - word address
//               write_data - store data
//               rdata      - registered read data (1-cycle latency)
//               rdata_en   - combinational read-select for the bus tri-state
//               irq        - expired & CTRL.IE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [8:0] BASE     = 9'h180,   // BASE[1:0] must be 2'b00
    parameter int         PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] rdata,
    output logic        rdata_en,
    output logic        irq
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    state_e      state_q,   state_d;
    logic        en_q,      en_d;
    logic        auto_q,    auto_d;
    logic        ie_q,      ie_d;
    logic        expired_q, expired_d;
    logic [15:0] load_q,    load_d;
    logic [15:0] count_q,   count_d;
    logic [15:0] rdata_q,   rdata_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       hit;
    logic [1:0] off;
    logic       wr_hit;
    logic       rd_hit;
    logic       wr_ctrl;
    logic       wr_load;
    logic       wr_count;
    logic       wr_status;

    assign hit       = (mem_addr[8:2] == BASE[8:2]);
    assign off       = mem_addr[1:0];
    assign wr_hit    = hit && (mem_cmd == MWRITE);
    assign rd_hit    = hit && (mem_cmd == MREAD);
    assign wr_ctrl   = wr_hit && (off == OFF_CTRL);
    assign wr_load   = wr_hit && (off == OFF_LOAD);
    assign wr_count  = wr_hit && (off == OFF_COUNT);
    assign wr_status = wr_hit && (off == OFF_STATUS);

    // ------------------------------------------------------------------
    // Control events
    // ------------------------------------------------------------------
    logic start;    // EN=1 write from IDLE/HALT: reload COUNT, clear prescaler
    logic stop;     // EN=0 write: wins over a tick on the same edge
    logic run;
    logic tick;

    assign start = wr_ctrl &&  write_data[EN] && (state_q != RUN);
    assign stop  = wr_ctrl && !write_data[EN];
    // Dropping run on a stop edge both discards the tick and freezes the
    // prescaler at its current value.
    assign run   = (state_q == RUN) && !stop;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clr   (start),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Statement order encodes the same-edge priorities:
    // expiry set follows the STATUS clear, and a software COUNT write is
    // applied last so it overrides any decrement or reload.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        auto_d    = auto_q;
        ie_d      = ie_q;
        expired_d = expired_q;
        load_d    = load_q;
        count_d   = count_q;
        rdata_d   = rdata_q;

        if (wr_status && write_data[0]) begin
            expired_d = 1'b0;
        end

        if (wr_ctrl) begin
            en_d   = write_data[EN];
            auto_d = write_data[AUTO];
            ie_d   = write_data[IE];
            if (start) begin
                state_d = RUN;
                count_d = load_q;
            end else if (stop && (state_q == RUN)) begin
                state_d = IDLE;
            end
        end

        if (wr_load) begin
            load_d = write_data;
        end

        if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                expired_d = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    en_d    = 1'b0;
                    state_d = HALT;
                end
            end
        end

        if (wr_count) begin
            count_d = write_data;
        end

        // Read data is captured from the pre-edge register values.
        if (rd_hit) begin
            case (off)
                OFF_CTRL:   rdata_d = {13'd0, ie_q, auto_q, en_q};
                OFF_LOAD:   rdata_d = load_q;
                OFF_COUNT:  rdata_d = count_q;
                default:    rdata_d = {15'd0, expired_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            expired_q <= 1'b0;
            load_q    <= 16'd0;
            count_q   <= 16'd0;
            rdata_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            expired_q <= expired_d;
            load_q    <= load_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdata    = rdata_q;
    assign rdata_en = rd_hit;
    assign irq      = expired_q & ie_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// ============================================================================
// Module      : tb_mmio_timer
// Description : Self-checking bench for mmio_timer. Two instances (PRESCALE 1
//               and 4) share one CPU bus. A behavioural model predicts every
//               register; reads push expected data into per-instance queues
//               that a negedge monitor pops and compares against rdata.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_timer;

    localparam logic [8:0] TB_BASE = 9'h180;
    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] rdata_a, rdata_b;
    logic        rdata_en_a, rdata_en_b;
    logic        irq_a, irq_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mmio_timer #(.BASE(TB_BASE), .PRESCALE(1)) u_dut_p1 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .rdata(rdata_a), .rdata_en(rdata_en_a), .irq(irq_a)
    );

    mmio_timer #(.BASE(TB_BASE), .PRESCALE(4)) u_dut_p4 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .rdata(rdata_b), .rdata_en(rdata_en_b), .irq(irq_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: index 0 = PRESCALE 1, index 1 = PRESCALE 4
    // ------------------------------------------------------------------
    logic        m_en[2], m_auto[2], m_ie[2], m_exp[2];
    logic [15:0] m_load[2], m_count[2], last_exp[2];
    int          m_el[2];              // running cycles since last start
    logic [15:0] sbq0[$], sbq1[$];

    function automatic int ps_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [15:0] reg_value(input int k, input logic [1:0] o);
        case (o)
            2'd0:    return {13'd0, m_ie[k], m_auto[k], m_en[k]};
            2'd1:    return m_load[k];
            2'd2:    return m_count[k];
            default: return {15'd0, m_exp[k]};
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_en[k] = 0; m_auto[k] = 0; m_ie[k] = 0; m_exp[k] = 0;
            m_load[k] = 0; m_count[k] = 0; last_exp[k] = 0; m_el[k] = 0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    task automatic model_edge(input int k);
        logic hit, wr, rd, stop, start, run_cyc, tick;
        logic [1:0] o;
        logic n_en, n_auto, n_ie, n_exp;
        logic [15:0] n_load, n_count;
        hit = ((mem_addr >> 2) == (TB_BASE >> 2));
        o   = mem_addr[1:0];
        wr  = hit && (mem_cmd == C_WRITE);
        rd  = hit && (mem_cmd == C_READ);
        if (rd) begin
            if (k == 0) sbq0.push_back(reg_value(k, o));
            else        sbq1.push_back(reg_value(k, o));
        end
        stop    = wr && (o == 2'd0) && !write_data[0];
        start   = wr && (o == 2'd0) &&  write_data[0] && !m_en[k];
        run_cyc = m_en[k] && !stop;
        tick    = run_cyc && (((m_el[k] + 1) % ps_of(k)) == 0);
        n_en = m_en[k]; n_auto = m_auto[k]; n_ie = m_ie[k]; n_exp = m_exp[k];
        n_load = m_load[k]; n_count = m_count[k];
        if (wr && o == 2'd3 && write_data[0]) n_exp = 0;
        if (wr && o == 2'd0) begin
            n_en = write_data[0]; n_auto = write_data[1]; n_ie = write_data[2];
        end
        if (start) n_count = m_load[k];
        if (wr && o == 2'd1) n_load = write_data;
        if (tick) begin
            if (m_count[k] != 0) n_count = m_count[k] - 16'd1;
            else begin
                n_exp = 1;
                if (m_auto[k]) n_count = m_load[k];
                else n_en = 0;
            end
        end
        if (wr && o == 2'd2) n_count = write_data;
        if (start) m_el[k] = 0;
        else if (run_cyc) m_el[k] = m_el[k] + 1;
        m_en[k] = n_en; m_auto[k] = n_auto; m_ie[k] = n_ie; m_exp[k] = n_exp;
        m_load[k] = n_load; m_count[k] = n_count;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_edge(0);
            model_edge(1);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pop expected read data when it appears, check held rdata
    // and irq every cycle.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (sbq0.size() > 0) last_exp[0] = sbq0.pop_front();
        if (sbq1.size() > 0) last_exp[1] = sbq1.pop_front();
        chk("rdata_p1", rdata_a, last_exp[0]);
        chk("rdata_p4", rdata_b, last_exp[1]);
        chk("irq_p1", 16'(irq_a), 16'(m_exp[0] & m_ie[0]));
        chk("irq_p4", 16'(irq_b), 16'(m_exp[1] & m_ie[1]));
    end

    // ------------------------------------------------------------------
    // Driver: called at a negedge, returns at the next negedge
    // ------------------------------------------------------------------
    task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        logic exp_en;
        mem_cmd = c; mem_addr = a; write_data = d;
        exp_en = (c == C_READ) && ((a >> 2) == (TB_BASE >> 2));
        #1;
        chk("rdata_en_p1", 16'(rdata_en_a), 16'(exp_en));
        chk("rdata_en_p4", 16'(rdata_en_b), 16'(exp_en));
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] o, input logic [15:0] d);
        bus(C_WRITE, TB_BASE | 9'(o), d);
    endtask

    task automatic rd(input logic [1:0] o);
        bus(C_READ, TB_BASE | 9'(o), 16'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(C_NONE, 9'd0, 16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ro;
        logic [15:0] rdv;
        int r;
        reset = 1'b0; mem_cmd = C_NONE; mem_addr = 9'd0; write_data = 16'd0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            rd(2'(i));
            chk("reset_reg_p1", rdata_a, 16'd0);
            chk("reset_reg_p4", rdata_b, 16'd0);
        end

        // One-shot on the PRESCALE=1 instance
        wr(2'd1, 16'd3);
        wr(2'd0, 16'd1);
        for (int i = 0; i < 4; i++) begin
            rd(2'd2);
            chk("oneshot_count", rdata_a, 16'(3 - i));
        end
        rd(2'd3); chk("oneshot_status", rdata_a, 16'd1);
        rd(2'd0); chk("oneshot_ctrl",   rdata_a, 16'd0);
        rd(2'd2); chk("oneshot_hold0",  rdata_a, 16'd0);

        // Auto-reload with interrupt on the PRESCALE=1 instance
        wr(2'd0, 16'd0);
        wr(2'd3, 16'd1);
        wr(2'd1, 16'd2);
        wr(2'd0, 16'd7);
        idle(1); chk("auto_irq_c1", 16'(irq_a), 16'd0);
        idle(1); chk("auto_irq_c2", 16'(irq_a), 16'd0);
        idle(1); chk("auto_irq_c3", 16'(irq_a), 16'd1);
        wr(2'd3, 16'd1); chk("auto_irq_clr", 16'(irq_a), 16'd0);
        idle(1); chk("auto_irq_r1", 16'(irq_a), 16'd0);
        idle(1); chk("auto_irq_r2", 16'(irq_a), 16'd1);

        // Collisions: LOAD=0 auto-reload expires on every tick
        wr(2'd0, 16'd0);
        wr(2'd1, 16'd0);
        wr(2'd0, 16'd3);
        idle(1);
        wr(2'd3, 16'd1);
        rd(2'd3); chk("coll_status_sticky", rdata_a, 16'd1);
        wr(2'd2, 16'h0050);
        rd(2'd2); chk("coll_count_write", rdata_a, 16'h0050);

        // Prescaler on the PRESCALE=4 instance
        wr(2'd0, 16'd0);
        wr(2'd1, 16'd10);
        wr(2'd0, 16'd1);
        for (int i = 0; i < 12; i++) begin
            rd(2'd2);
            chk("presc_count", rdata_b, 16'(10 - i / 4));
        end
        wr(2'd0, 16'd0);
        for (int i = 0; i < 6; i++) begin
            rd(2'd2);
            chk("presc_stop_hold", rdata_b, 16'd7);
        end

        // Decode
        wr(2'd1, 16'h1234);
        bus(C_WRITE, 9'h100, 16'hFFFF);
        bus(C_WRITE, 9'h184, 16'hFFFF);
        rd(2'd1); chk("decode_load", rdata_a, 16'h1234);
        rd(2'd0); chk("decode_ctrl", rdata_a, 16'd0);
        wr(2'd2, 16'h00AB);
        bus(C_READ, 9'h140, 16'd0);
        chk("decode_hold", rdata_a, 16'd0);
        bus(C_READ, 9'h182, 16'd0);
        chk("decode_count", rdata_a, 16'h00AB);

        // Asynchronous reset mid-operation
        wr(2'd1, 16'd5);
        wr(2'd0, 16'd5);
        idle(2);
        mem_cmd = C_NONE;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_rdata", rdata_a, 16'd0);
        chk("async_rst_irq",   16'(irq_a), 16'd0);
        chk("async_rst_en",    16'(rdata_en_a), 16'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i));
            chk("post_rst_p1", rdata_a, 16'd0);
            chk("post_rst_p4", rdata_b, 16'd0);
        end

        // Randomized traffic checked by the model
        for (int i = 0; i < 700; i++) begin
            r  = $urandom_range(0, 9);
            ro = 2'($urandom_range(0, 3));
            if (r < 3) begin
                idle(1);
            end else if (r < 6) begin
                rd(ro);
            end else if (r == 9) begin
                bus(($urandom_range(0, 1) == 0) ? C_READ : C_WRITE,
                    9'($urandom_range(0, 511)), 16'($urandom));
            end else begin
                case (ro)
                    2'd0:    rdv = {13'($urandom), 3'($urandom_range(0, 7))};
                    2'd1:    rdv = 16'($urandom_range(0, 6));
                    2'd2:    rdv = 16'($urandom_range(0, 8));
                    default: rdv = 16'($urandom_range(0, 1));
                endcase
                wr(ro, rdv);
            end
        end

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
